cpuif_fanout: RTL and testbench

Parametrised 1-to-N splitter for the PeakRDL-style CPU register interface. One upstream master port is routed by address to N downstream register blocks. It adds what the plain interface lacks: decode-error, per-access timeout and spurious-ack detection. It sits between the host bridge and the per-peripheral register blocks, with one access outstanding at a time.

---
 rtl/cpuif_fanout_pkg.sv | 18 +
 rtl/cpuif_fanout_timeout_ctr.sv | 36 +++
 rtl/cpuif_fanout.sv | 171 +++++++++++++++++
 tb/tb_cpuif_fanout.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpuif_fanout_pkg.sv
// rtl/cpuif_fanout_pkg.sv - state encoding and address decode shared by the cpuif fanout
package pkg_cpuif_fanout;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    RESP   = 3'd3,
    DECERR = 3'd4,
    TOUT   = 3'd5
  } state_e;

  // Slave index is everything above the per-slave window; out-of-range values are decode misses.
  function automatic logic [31:0] sel_of(input logic [31:0] addr, input int slv_addr_w);
    return addr >> slv_addr_w;
  endfunction

endpackage

// File: rtl/cpuif_fanout_timeout_ctr.sv
// rtl/cpuif_fanout_timeout_ctr.sv - per-access cycle counter that flags expiry at TIMEOUT cycles
module cpuif_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Expiry is flagged in the cycle the count reaches TIMEOUT, so a same-cycle ack can still win.
  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired_o = 1'b0;
    end else begin : g_on
      assign expired_o = en_i && !clear_i && (cnt_q == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/cpuif_fanout.sv
// rtl/cpuif_fanout.sv - 1-to-N CPU register interface splitter with decode, timeout and spurious-ack checks
module cpuif_fanout
  import pkg_cpuif_fanout::*;
#(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 16,
  parameter int N_SLV      = 4,
  parameter int SLV_ADDR_W = 11,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_req,
  input  logic                    s_req_is_wr,
  input  logic [ADDR_W-1:0]       s_addr,
  input  logic [DATA_W-1:0]       s_wr_data,
  input  logic [DATA_W-1:0]       s_wr_biten,
  output logic                    s_req_stall_wr,
  output logic                    s_req_stall_rd,
  output logic                    s_rd_ack,
  output logic                    s_rd_err,
  output logic [DATA_W-1:0]       s_rd_data,
  output logic                    s_wr_ack,
  output logic                    s_wr_err,
  output logic [N_SLV-1:0]        m_req,
  output logic                    m_req_is_wr,
  output logic [SLV_ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]       m_wr_data,
  output logic [DATA_W-1:0]       m_wr_biten,
  input  logic [N_SLV-1:0]        m_req_stall_wr,
  input  logic [N_SLV-1:0]        m_req_stall_rd,
  input  logic [N_SLV-1:0]        m_rd_ack,
  input  logic [N_SLV-1:0]        m_rd_err,
  input  logic [N_SLV*DATA_W-1:0] m_rd_data,
  input  logic [N_SLV-1:0]        m_wr_ack,
  input  logic [N_SLV-1:0]        m_wr_err,
  output logic                    stat_decerr,
  output logic                    stat_timeout,
  output logic                    stat_spurious
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  state_e                state_q, state_d;
  logic                  is_wr_q, is_wr_d;
  logic [SLV_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     biten_q, biten_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  spur_q, spur_d;

  logic [31:0]       idx;
  logic [N_SLV-1:0]  sel_oh, exp_rd, exp_wr;
  logic [DATA_W-1:0] sel_rdata;
  logic              accept, busy, stalled, ack_window, ack_hit, ack_err, expired;
  logic              done, fault;

  assign idx    = sel_of(32'(s_addr), SLV_ADDR_W);
  assign accept = s_req && (state_q == IDLE);
  assign busy   = (state_q == ISSUE) || (state_q == WAIT);

  always_comb begin
    sel_oh    = '0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      sel_oh[i] = (sel_q == IDX_W'(i));
      if (sel_q == IDX_W'(i)) sel_rdata = m_rd_data[i*DATA_W +: DATA_W];
    end
  end

  // Only the selected slave's ack of the issued type, once the request has left the stall, counts.
  assign stalled    = is_wr_q ? |(m_req_stall_wr & sel_oh) : |(m_req_stall_rd & sel_oh);
  assign ack_window = ((state_q == ISSUE) && !stalled) || (state_q == WAIT);
  assign exp_rd     = (ack_window && !is_wr_q) ? sel_oh : '0;
  assign exp_wr     = (ack_window &&  is_wr_q) ? sel_oh : '0;
  assign ack_hit    = |(m_rd_ack & exp_rd) | |(m_wr_ack & exp_wr);
  assign ack_err    = |(m_rd_ack & m_rd_err & exp_rd) | |(m_wr_ack & m_wr_err & exp_wr);
  assign spur_d     = |(m_rd_ack & ~exp_rd) | |(m_wr_ack & ~exp_wr);

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    biten_d = biten_q;
    sel_d   = sel_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (s_req) begin
          is_wr_d = s_req_is_wr;
          addr_d  = s_addr[SLV_ADDR_W-1:0];
          wdata_d = s_wr_data;
          biten_d = s_wr_biten;
          sel_d   = idx[IDX_W-1:0];
          if (idx < 32'(N_SLV)) state_d = ISSUE;
          else                  state_d = DECERR;
        end
      end
      ISSUE, WAIT: begin
        if (ack_hit) begin
          state_d = RESP;
          err_d   = ack_err;
          rdata_d = is_wr_q ? '0 : sel_rdata;
        end else if (expired) begin
          state_d = TOUT;
        end else if ((state_q == ISSUE) && !stalled) begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      biten_q <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      biten_q <= biten_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      spur_q  <= spur_d;
    end
  end

  cpuif_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (accept),
    .en_i      (busy),
    .expired_o (expired)
  );

  assign done  = (state_q == RESP) || (state_q == DECERR) || (state_q == TOUT);
  assign fault = (state_q == DECERR) || (state_q == TOUT);

  assign s_req_stall_wr = (state_q != IDLE);
  assign s_req_stall_rd = (state_q != IDLE);
  assign s_rd_ack       = done && !is_wr_q;
  assign s_wr_ack       = done &&  is_wr_q;
  assign s_rd_err       = s_rd_ack && (fault || err_q);
  assign s_wr_err       = s_wr_ack && (fault || err_q);
  assign s_rd_data      = ((state_q == RESP) && !is_wr_q) ? rdata_q : '0;

  assign m_req       = (state_q == ISSUE) ? sel_oh : '0;
  assign m_req_is_wr = is_wr_q;
  assign m_addr      = addr_q;
  assign m_wr_data   = wdata_q;
  assign m_wr_biten  = biten_q;

  assign stat_decerr   = (state_q == DECERR);
  assign stat_timeout  = (state_q == TOUT);
  assign stat_spurious = spur_q;

endmodule

// File: tb/tb_cpuif_fanout.sv
// tb/tb_cpuif_fanout.sv - vector table plus scoreboard bench for cpuif_fanout with a behavioural slave model
module tb_cpuif_fanout;

  localparam int ADDR_W = 13, DATA_W = 16, N_SLV = 3, SLV_ADDR_W = 11, TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic s_req, s_req_is_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wr_data, s_wr_biten;
  logic s_req_stall_wr, s_req_stall_rd, s_rd_ack, s_rd_err, s_wr_ack, s_wr_err;
  logic [DATA_W-1:0] s_rd_data;
  logic [N_SLV-1:0] m_req;
  logic m_req_is_wr;
  logic [SLV_ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wr_data, m_wr_biten;
  logic [N_SLV-1:0] m_req_stall_wr, m_req_stall_rd, m_rd_ack, m_rd_err, m_wr_ack, m_wr_err;
  logic [N_SLV*DATA_W-1:0] m_rd_data;
  logic stat_decerr, stat_timeout, stat_spurious;

  always #5 clk = ~clk;

  cpuif_fanout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLV(N_SLV), .SLV_ADDR_W(SLV_ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .s_req(s_req), .s_req_is_wr(s_req_is_wr), .s_addr(s_addr),
    .s_wr_data(s_wr_data), .s_wr_biten(s_wr_biten), .s_req_stall_wr(s_req_stall_wr),
    .s_req_stall_rd(s_req_stall_rd), .s_rd_ack(s_rd_ack), .s_rd_err(s_rd_err), .s_rd_data(s_rd_data),
    .s_wr_ack(s_wr_ack), .s_wr_err(s_wr_err), .m_req(m_req), .m_req_is_wr(m_req_is_wr), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_wr_biten(m_wr_biten), .m_req_stall_wr(m_req_stall_wr),
    .m_req_stall_rd(m_req_stall_rd), .m_rd_ack(m_rd_ack), .m_rd_err(m_rd_err), .m_rd_data(m_rd_data),
    .m_wr_ack(m_wr_ack), .m_wr_err(m_wr_err), .stat_decerr(stat_decerr), .stat_timeout(stat_timeout),
    .stat_spurious(stat_spurious)
  );

  typedef struct {
    logic        is_wr;
    logic [12:0] addr;
    logic [15:0] wdata;
    logic [15:0] biten;
    int          stall;
    int          lat;
    logic [15:0] sdata;
    logic        serr;
    logic [2:0]  exp_mreq;
    logic [10:0] exp_maddr;
    logic        exp_err;
    logic [15:0] exp_data;
    int          exp_lat;
    int          exp_dec;
    int          exp_tout;
  } vec_t;

  typedef struct {
    logic        is_wr;
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[9];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int stall_left[N_SLV], lat_cfg[N_SLV], cdown[N_SLV];
  logic cur_wr[N_SLV];
  logic [15:0] sdata[N_SLV];
  logic serr[N_SLV];
  logic [N_SLV-1:0] inj_rd, inj_wr;

  logic [N_SLV-1:0] mreq_seen;
  logic [10:0] mreq_addr;
  logic mreq_wr;
  logic [15:0] mreq_data, mreq_biten;
  int mreq_cycles, stall_hi, ack_cnt, ack_cyc, n_dec, n_tout, n_spur, rd_idle_viol, n_unexp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic any_out();
    return |{s_req_stall_wr, s_req_stall_rd, s_rd_ack, s_rd_err, s_rd_data, s_wr_ack, s_wr_err,
             m_req, m_req_is_wr, m_addr, m_wr_data, m_wr_biten, stat_decerr, stat_timeout, stat_spurious};
  endfunction

  // One cycle: observe outputs at the falling edge, then drive slave responses for the next rising edge.
  task automatic step();
    @(negedge clk);
    if (m_req != '0) begin
      mreq_seen  = mreq_seen | m_req;
      mreq_addr  = m_addr;
      mreq_wr    = m_req_is_wr;
      mreq_data  = m_wr_data;
      mreq_biten = m_wr_biten;
      mreq_cycles++;
      if (s_req_stall_wr && s_req_stall_rd) stall_hi++;
    end
    if (!s_rd_ack && s_rd_data != '0) rd_idle_viol++;
    n_dec  += int'(stat_decerr);
    n_tout += int'(stat_timeout);
    n_spur += int'(stat_spurious);
    if (s_rd_ack || s_wr_ack) begin
      ack_cnt++;
      ack_cyc = cyc;
      if (sb_q.size() == 0) n_unexp++;
      else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ack_type", {31'd0, s_wr_ack}, {31'd0, e.is_wr});
        check("ack_err", {31'd0, (e.is_wr ? s_wr_err : s_rd_err)}, {31'd0, e.err});
        if (!e.is_wr) check("rd_data", {16'd0, s_rd_data}, {16'd0, e.data});
      end
    end
    m_req_stall_wr = '0; m_req_stall_rd = '0; m_rd_ack = '0; m_wr_ack = '0;
    for (int i = 0; i < N_SLV; i++) begin
      m_rd_data[i*DATA_W +: DATA_W] = sdata[i];
      m_rd_err[i] = serr[i];
      m_wr_err[i] = serr[i];
      if (cdown[i] > 0) begin
        cdown[i]--;
        if (cdown[i] == 0) begin
          if (cur_wr[i]) m_wr_ack[i] = 1'b1;
          else           m_rd_ack[i] = 1'b1;
        end
      end
      if (m_req[i]) begin
        cur_wr[i] = m_req_is_wr;
        if (stall_left[i] > 0) begin
          stall_left[i]--;
          if (m_req_is_wr) m_req_stall_wr[i] = 1'b1;
          else             m_req_stall_rd[i] = 1'b1;
        end else if (lat_cfg[i] == 0) begin
          if (m_req_is_wr) m_wr_ack[i] = 1'b1;
          else             m_rd_ack[i] = 1'b1;
        end else if (lat_cfg[i] > 0) begin
          cdown[i] = lat_cfg[i];
        end
      end
    end
    m_rd_ack = m_rd_ack | inj_rd;
    m_wr_ack = m_wr_ack | inj_wr;
    inj_rd = '0;
    inj_wr = '0;
  endtask

  task automatic do_access(input logic wr, input logic [12:0] addr, input logic [15:0] wd, input logic [15:0] be,
                           input logic exp_err, input logic [15:0] exp_data, output int t_acc);
    int guard;
    exp_t e;
    guard = 0;
    s_req = 1'b1; s_req_is_wr = wr; s_addr = addr; s_wr_data = wd; s_wr_biten = be;
    while (s_req_stall_wr && guard < 50) begin
      step();
      guard++;
    end
    check("accept_bound", {31'd0, guard < 50}, 32'd1);
    t_acc = cyc;
    e.is_wr = wr; e.err = exp_err; e.data = exp_data;
    sb_q.push_back(e);
    step();
    s_req = 1'b0;
  endtask

  task automatic wait_ack(input int a0, input int budget);
    int n;
    n = 0;
    while (ack_cnt == a0 && n < budget) begin
      step();
      n++;
    end
    check("ack_bound", {31'd0, ack_cnt != a0}, 32'd1);
  endtask

  task automatic clear_mon();
    mreq_seen = '0; mreq_cycles = 0; stall_hi = 0; n_dec = 0; n_tout = 0; n_spur = 0;
  endtask

  initial begin
    int t_acc, t1, t2, a0, idx, guard;
    vec_t v;

    vecs[0] = '{1'b0, 13'h0804, 16'h0000, 16'h0000, 0,  3, 16'hBEEF, 1'b0, 3'b010, 11'h004, 1'b0, 16'hBEEF, 5, 0, 0};
    vecs[1] = '{1'b1, 13'h1FFE, 16'h5555, 16'hFFFF, 0,  1, 16'h0000, 1'b0, 3'b000, 11'h7FE, 1'b1, 16'h0000, 1, 1, 0};
    vecs[2] = '{1'b0, 13'h1010, 16'h0000, 16'h0000, 0, -1, 16'hDEAD, 1'b0, 3'b100, 11'h010, 1'b1, 16'h0000, 9, 0, 1};
    vecs[3] = '{1'b1, 13'h0020, 16'hCAFE, 16'h00FF, 4,  1, 16'h0000, 1'b0, 3'b001, 11'h020, 1'b0, 16'h0000, 7, 0, 0};
    vecs[4] = '{1'b0, 13'h1100, 16'h0000, 16'h0000, 0,  0, 16'h1234, 1'b0, 3'b100, 11'h100, 1'b0, 16'h1234, 2, 0, 0};
    vecs[5] = '{1'b0, 13'h0FFF, 16'h0000, 16'h0000, 0,  1, 16'hA5A5, 1'b1, 3'b010, 11'h7FF, 1'b1, 16'hA5A5, 3, 0, 0};
    vecs[6] = '{1'b0, 13'h0002, 16'h0000, 16'h0000, 0,  7, 16'h7777, 1'b0, 3'b001, 11'h002, 1'b0, 16'h7777, 9, 0, 0};
    vecs[7] = '{1'b1, 13'h1002, 16'h0F0F, 16'hF000, 2,  0, 16'h0000, 1'b1, 3'b100, 11'h002, 1'b1, 16'h0000, 4, 0, 0};
    vecs[8] = '{1'b0, 13'h1800, 16'h0000, 16'h0000, 0,  1, 16'h0000, 1'b0, 3'b000, 11'h000, 1'b1, 16'h0000, 1, 1, 0};

    rst_n = 1'b0; s_req = 1'b0; s_req_is_wr = 1'b0; s_addr = '0; s_wr_data = '0; s_wr_biten = '0;
    m_req_stall_wr = '0; m_req_stall_rd = '0; m_rd_ack = '0; m_wr_ack = '0; m_rd_err = '0; m_wr_err = '0;
    m_rd_data = '0; inj_rd = '0; inj_wr = '0;
    ack_cnt = 0; ack_cyc = 0; rd_idle_viol = 0; n_unexp = 0; mreq_addr = '0; mreq_wr = 1'b0;
    mreq_data = '0; mreq_biten = '0;
    for (int i = 0; i < N_SLV; i++) begin
      stall_left[i] = 0; lat_cfg[i] = 1; cdown[i] = 0; cur_wr[i] = 1'b0; sdata[i] = '0; serr[i] = 1'b0;
    end
    clear_mon();

    step(); step();
    check("reset_outputs_zero", {31'd0, any_out()}, 32'd0);
    rst_n = 1'b1;
    step();
    check("reset_idle_no_stall", {31'd0, s_req_stall_rd}, 32'd0);

    foreach (vecs[k]) begin
      v = vecs[k];
      idx = int'(v.addr[12:11]);
      if (idx < N_SLV) begin
        stall_left[idx] = v.stall; lat_cfg[idx] = v.lat; sdata[idx] = v.sdata; serr[idx] = v.serr;
      end
      clear_mon();
      a0 = ack_cnt;
      do_access(v.is_wr, v.addr, v.wdata, v.biten, v.exp_err, v.exp_data, t_acc);
      wait_ack(a0, 40);
      check($sformatf("v%0d_latency", k), ack_cyc - t_acc, v.exp_lat);
      check($sformatf("v%0d_m_req", k), {29'd0, mreq_seen}, {29'd0, v.exp_mreq});
      check($sformatf("v%0d_decerr", k), n_dec, v.exp_dec);
      check($sformatf("v%0d_timeout", k), n_tout, v.exp_tout);
      if (v.exp_mreq != 3'b000) begin
        check($sformatf("v%0d_m_addr", k), {21'd0, mreq_addr}, {21'd0, v.exp_maddr});
        check($sformatf("v%0d_m_is_wr", k), {31'd0, mreq_wr}, {31'd0, v.is_wr});
        check($sformatf("v%0d_m_req_cycles", k), mreq_cycles, v.stall + 1);
        check($sformatf("v%0d_stall_held", k), stall_hi, mreq_cycles);
        if (v.is_wr) begin
          check($sformatf("v%0d_m_wr_data", k), {16'd0, mreq_data}, {16'd0, v.wdata});
          check($sformatf("v%0d_m_wr_biten", k), {16'd0, mreq_biten}, {16'd0, v.biten});
        end
      end
      step();
      check($sformatf("v%0d_no_spurious", k), n_spur, 0);
    end

    // Late ack from a slave that already timed out.
    clear_mon(); lat_cfg[2] = -1; a0 = ack_cnt;
    do_access(1'b0, 13'h1010, 16'h0, 16'h0, 1'b1, 16'h0000, t_acc);
    wait_ack(a0, 40);
    check("late_tout_latency", ack_cyc - t_acc, 9);
    repeat (4) step();
    inj_rd[2] = 1'b1;
    repeat (3) step();
    check("late_ack_spurious", n_spur, 1);
    check("late_ack_no_upstream", ack_cnt - a0, 1);

    // Wrong slave and wrong type acks while waiting on slave 1.
    clear_mon(); lat_cfg[1] = 4; sdata[1] = 16'h6B6B; serr[1] = 1'b0; a0 = ack_cnt;
    do_access(1'b0, 13'h0810, 16'h0, 16'h0, 1'b0, 16'h6B6B, t_acc);
    inj_rd[0] = 1'b1; inj_wr[1] = 1'b1;
    wait_ack(a0, 40);
    check("wrong_ack_latency", ack_cyc - t_acc, 6);
    check("wrong_ack_spurious", n_spur, 1);

    // Zero-latency slave with a back-to-back upstream request.
    step();
    lat_cfg[2] = 0; sdata[2] = 16'h1234; serr[2] = 1'b0; clear_mon(); a0 = ack_cnt;
    check("b2b_idle", {31'd0, s_req_stall_rd}, 32'd0);
    s_req = 1'b1; s_req_is_wr = 1'b0; s_addr = 13'h1100;
    t1 = cyc;
    sb_q.push_back('{1'b0, 1'b0, 16'h1234});
    step();
    s_addr = 13'h1200;
    guard = 0;
    while (s_req_stall_rd && guard < 20) begin
      step();
      guard++;
    end
    t2 = cyc;
    check("b2b_first_ack", ack_cyc - t1, 2);
    check("b2b_accept_gap", t2 - t1, 3);
    sb_q.push_back('{1'b0, 1'b0, 16'h1234});
    step();
    s_req = 1'b0;
    wait_ack(a0 + 1, 20);
    check("b2b_second_latency", ack_cyc - t2, 2);
    check("b2b_second_addr", {21'd0, mreq_addr}, 32'h200);

    // Reset while an access is waiting on its slave.
    step();
    lat_cfg[1] = -1; sdata[1] = 16'h4321;
    do_access(1'b0, 13'h0840, 16'h0, 16'h0, 1'b0, 16'h4321, t_acc);
    step(); step();
    check("pre_reset_busy", {31'd0, s_req_stall_rd}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs_zero", {31'd0, any_out()}, 32'd0);
    sb_q.delete();
    for (int i = 0; i < N_SLV; i++) cdown[i] = 0;
    lat_cfg[1] = 1;
    a0 = ack_cnt;
    step(); step();
    rst_n = 1'b1;
    check("reset_no_ack", ack_cnt - a0, 0);
    step();
    clear_mon(); a0 = ack_cnt;
    do_access(1'b0, 13'h0840, 16'h0, 16'h0, 1'b0, 16'h4321, t_acc);
    wait_ack(a0, 20);
    check("post_reset_latency", ack_cyc - t_acc, 3);
    check("post_reset_m_addr", {21'd0, mreq_addr}, 32'h040);

    repeat (2) step();
    check("rd_data_zero_when_idle", rd_idle_viol, 0);
    check("unexpected_upstream_acks", n_unexp, 0);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
